// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, Wishbone classic fetch FSM, IF/ID register.
// Define IF_PERF_CNT_EN to add fetch/stall performance counters.
module if_fetch_stage #(
   parameter logic [31:0] PC_ADDR    = 32'h8000_0000,
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            stall_and_flush,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  wbm_cyc_o,
   output logic                  wbm_stb_o,
   output logic                  wbm_we_o,
   output logic [3:0]            wbm_sel_o,
   output logic [ADDR_WIDTH-1:0] wbm_adr_o,
   input  logic [DATA_WIDTH-1:0] wbm_dat_i,
   input  logic                  wbm_ack_i,
   output logic                  ifid_valid_o,
   output logic [ADDR_WIDTH-1:0] ifid_pc_o,
   output logic [DATA_WIDTH-1:0] ifid_inst_o,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]           perf_fetch_cnt_o,
   output logic [31:0]           perf_stall_cnt_o,
`endif
   output logic                  if_busy_o
);

   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_DONE  = 1'b1;

   logic [0:0]            state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [DATA_WIDTH-1:0] buf_r;
   logic                  redirect_pend;
   logic [ADDR_WIDTH-1:0] redirect_tgt;

   logic                  stall;
   logic                  flush;
   logic                  in_fetch;
   logic                  in_done;
   logic [ADDR_WIDTH-1:0] redir_pc;

   logic                  ack_redir;
   logic                  ack_take;
   logic                  wait_redir;
   logic                  done_redir;
   logic                  done_load;

   assign stall    = stall_and_flush[1];
   assign flush    = stall_and_flush[0];
   assign in_fetch = (state_r == S_FETCH);
   assign in_done  = (state_r == S_DONE);
   assign redir_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

   // Bits [1:0] of the redirect target are forced to zero.
   logic unused_ok;
   assign unused_ok = &{1'b0, redirect_pc_i[1:0]};

   // Mutually exclusive FSM events for this cycle.
   always_comb begin
      ack_redir  = 1'b0;
      ack_take   = 1'b0;
      wait_redir = 1'b0;
      done_redir = 1'b0;
      done_load  = 1'b0;
      if (in_fetch) begin
         ack_redir  = wbm_ack_i & (redirect_valid_i | redirect_pend);
         ack_take   = wbm_ack_i & ~redirect_valid_i & ~redirect_pend;
         wait_redir = ~wbm_ack_i & redirect_valid_i;
      end
      if (in_done) begin
         done_redir = redirect_valid_i;
         done_load  = ~redirect_valid_i & ~stall & ~flush;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r       <= S_FETCH;
         pc_r          <= PC_ADDR[ADDR_WIDTH-1:0];
         buf_r         <= '0;
         redirect_pend <= 1'b0;
         redirect_tgt  <= '0;
      end else begin
         unique case (1'b1)
            ack_redir: begin
               pc_r          <= redirect_valid_i ? redir_pc : redirect_tgt;
               redirect_pend <= 1'b0;
            end
            ack_take: begin
               buf_r   <= wbm_dat_i;
               state_r <= S_DONE;
            end
            wait_redir: begin
               redirect_pend <= 1'b1;
               redirect_tgt  <= redir_pc;
            end
            done_redir: begin
               buf_r   <= '0;
               pc_r    <= redir_pc;
               state_r <= S_FETCH;
            end
            done_load: begin
               pc_r    <= pc_r + ADDR_WIDTH'(4);
               state_r <= S_FETCH;
            end
            default: begin
            end
         endcase
      end
   end

   // Redirect beats stall; stall beats flush; otherwise load or bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ifid_valid_o <= 1'b0;
         ifid_pc_o    <= '0;
         ifid_inst_o  <= '0;
      end else if (redirect_valid_i) begin
         ifid_valid_o <= 1'b0;
      end else if (stall) begin
         ifid_valid_o <= ifid_valid_o;
      end else if (flush) begin
         ifid_valid_o <= 1'b0;
      end else if (done_load) begin
         ifid_valid_o <= 1'b1;
         ifid_pc_o    <= pc_r;
         ifid_inst_o  <= buf_r;
      end else begin
         ifid_valid_o <= 1'b0;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_fetch_cnt_o <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         if (done_load)
            perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
         if (stall)
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
   end
`endif

   // Bus request drops combinationally while reset is held.
   assign wbm_cyc_o = in_fetch & ~rst_i;
   assign wbm_stb_o = in_fetch & ~rst_i;
   assign if_busy_o = in_fetch & ~rst_i;
   assign wbm_we_o  = 1'b0;
   assign wbm_sel_o = 4'b1111;
   assign wbm_adr_o = pc_r;

endmodule
